ssd_debug_display: RTL
======================

// Module: ssd_debug_display
// PURPOSE
//  FPGA debug front end downstream of the full datapath.
//  - Consumes the datapath's 12 debug buses and shows one 16-bit half of a selected bus on a 4-digit seven-segment display.
//  - Debounces two board buttons.
//  - Produces a one-cycle step pulse that drives the datapath's clock enable for single-stepping.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive identical synced samples needed to accept a button level
//  REFRESH_DIV      50000   clk cycles each digit stays lit before the scan advances
// PORTS
//  clk         in   1    system clock; all logic on rising edge
//  reset       in   1    synchronous, active-high; clears all state
//  dbg_bus     in   384  word k at [32k+31:32k]: 0 PC, 1 PC+4, 2 branch target, 3 PC next, 4 rs1, 5 rs2, 6 wb data, 7 imm, 8 shifted imm, 9 ALU B, 10 ALU result, 11 dmem out
//  sel         in   4    switch select of word k; values 12..15 blank the display
//  btn_step    in   1    raw asynchronous step button, active-high
//  btn_page    in   1    raw asynchronous page button, active-high
//  step_pulse  out  1    one-cycle pulse per accepted press of btn_step
//  page        out  1    0 = show bits [15:0]; 1 = show bits [31:16]
//  anode       out  4    digit enables, active-low; anode[0] is the rightmost digit
//  seg         out  7    segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset values (registered, applied in the cycle reset is sampled high):
//   step_pulse=0, page=0, anode=4'b1110, seg=7'b1000000 ("0").
//   Digit index=0, refresh count=0, latched value=16'h0000.
//   Debounced levels=0, debounce counters=0, synchronisers=0.
//  Input sync: each button goes through a 2-FF synchroniser.
//  Debounce, per button:
//   - Synced sample != debounced level: counter increments.
//   - Synced sample == debounced level: counter clears.
//   - Counter reaching DEBOUNCE_CYCLES-1 while the sample still differs: the level flips and the counter clears.
//   - Any shorter glitch is discarded.
//  Edge detect: a 0->1 flip of the debounced level gives exactly one pulse.
//   - btn_step: step_pulse=1 on the next cycle.
//   - btn_page: page toggles on the next cycle.
//   - Holding a button or releasing it generates nothing.
//   - Both buttons accepted in the same cycle: both actions occur in that cycle.
//  Scan:
//   - Refresh count runs 0..REFRESH_DIV-1 and wraps.
//   - On the wrap cycle the digit index advances 0->1->2->3->0.
//  Snapshot (prevents tearing):
//   - Taken when the index advances from 3 to 0 (and on reset release).
//   - Value = dbg_bus word[sel], half chosen by page.
//   - A change of sel or page inside a frame takes effect at the next frame start.
//  Digit n shows nibble [4n+3:4n] of the snapshot, standard hex glyphs 0-F.
//   - Hex patterns (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  Output timing: anode and seg update together, one cycle after the index changes. They must never show a new anode with the old digit's segments.
//  sel >= 12 at the snapshot: seg=7'b1111111 for the whole frame; anode keeps scanning.
//  Reset mid-frame or mid-debounce: everything returns to reset values and no pulse is emitted.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, REFRESH_DIV=3)
//  1. Reset, dbg_bus word0=32'h1234ABCD, sel=0, page=0 -> after the first frame, scan shows D,C,B,A on anode 1110,1101,1011,0111, each held 3 cycles.
//  2. btn_step high 2 cycles then low -> step_pulse stays 0. btn_step high 10 cycles -> exactly one step_pulse.
//  3. Press btn_page (held 8 cycles) mid-frame, word0=32'h1234ABCD -> page=1; the current frame still shows ABCD, the next frame shows 4,3,2,1.
//  4. sel=4'd13 -> seg=7'h7F on all digits while anode keeps cycling. Then sel=10 with ALU word=32'h0000_00F0 -> digits 0,F,0,0.
//  5. Reset asserted during debounce count 2 and mid-scan at digit 2 -> next cycle anode=1110, seg=7'h40, page=0, and no step_pulse after release.
//  6. btn_step and btn_page accepted in the same cycle -> step_pulse=1 and page toggles in the same cycle.

Source files
------------

// File: rtl/ssd_debug_display_if.sv
// -----------------------------------------------------------------------------
// ssd_debug_display_if
//   Groups the debug front end's board/datapath-facing signals.
//   dbg_bus    : 12 x 32-bit datapath debug words, word k at [32k+31:32k]
//   sel        : word select (12..15 blank the display)
//   btn_step   : raw step button, active-high, asynchronous
//   btn_page   : raw page button, active-high, asynchronous
//   step_pulse : one-cycle pulse per accepted step press
//   page       : 0 shows bits [15:0], 1 shows bits [31:16]
//   anode      : active-low digit enables, anode[0] rightmost
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   master = environment driving the display, slave = the display itself.
// -----------------------------------------------------------------------------
interface ssd_debug_display_if;
   logic [383:0] dbg_bus;
   logic [3:0]   sel;
   logic         btn_step;
   logic         btn_page;
   logic         step_pulse;
   logic         page;
   logic [3:0]   anode;
   logic [6:0]   seg;

   modport master (
      output dbg_bus, sel, btn_step, btn_page,
      input  step_pulse, page, anode, seg
   );

   modport slave (
      input  dbg_bus, sel, btn_step, btn_page,
      output step_pulse, page, anode, seg
   );
endinterface

// File: rtl/ssd_debug_display.sv
// -----------------------------------------------------------------------------
// ssd_debug_display
//   FPGA debug front end: debounces the step/page buttons, emits a one-cycle
//   step pulse, and scans one 16-bit half of a selected debug word onto a
//   4-digit multiplexed seven-segment display.
// Ports
//   clk   : system clock, rising edge
//   reset : synchronous, active-high, clears all state
//   bus   : ssd_debug_display_if.slave (dbg_bus, sel, buttons in;
//           step_pulse, page, anode, seg out)
// -----------------------------------------------------------------------------
module ssd_debug_display #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REFRESH_DIV     = 50000
) (
   input logic                 clk,
   input logic                 reset,
   ssd_debug_display_if.slave  bus
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RF_W-1:0] RF_MAX = RF_W'(REFRESH_DIV - 1);

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      case (nib)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   // bit 0 = step button, bit 1 = page button
   logic [1:0]      sync1_q, sync2_q, lvl_q, lvl_d, rise;
   logic [DB_W-1:0] cnt_q [2];
   logic [DB_W-1:0] cnt_d [2];
   logic            step_pulse_q, step_pulse_d, page_q, page_d;

   logic [RF_W-1:0] ref_q, ref_d;
   logic [1:0]      idx_q, idx_d;
   logic            pend_q;
   logic            load;
   logic [31:0]     word;
   logic [15:0]     snap_q, snap_d;
   logic            blank_q, blank_d;
   logic [3:0]      anode_q, anode_d;
   logic [6:0]      seg_q, seg_d;

   // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing
   // synced samples; any equal sample restarts the count.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         lvl_d[b] = lvl_q[b];
         cnt_d[b] = '0;
         if (sync2_q[b] != lvl_q[b]) begin
            if (cnt_q[b] == DB_MAX) lvl_d[b] = ~lvl_q[b];
            else                    cnt_d[b] = cnt_q[b] + DB_W'(1);
         end
      end
      rise         = lvl_d & ~lvl_q;
      step_pulse_d = rise[0];
      page_d       = page_q ^ rise[1];
   end

   // Scan and snapshot: the display value is frozen for a whole frame so a
   // sel/page change never mixes halves or words across digits.
   always_comb begin
      word = '0;
      for (int k = 0; k < 12; k++) begin
         if (bus.sel == 4'(k)) word = bus.dbg_bus[32*k +: 32];
      end
      ref_d = (ref_q == RF_MAX) ? '0 : ref_q + RF_W'(1);
      idx_d = (ref_q == RF_MAX) ? idx_q + 2'd1 : idx_q;
      load  = pend_q || ((ref_q == RF_MAX) && (idx_q == 2'd3));
      snap_d  = snap_q;
      blank_d = blank_q;
      if (load) begin
         snap_d  = page_q ? word[31:16] : word[15:0];
         blank_d = (bus.sel >= 4'd12);
      end
      // anode and seg both derive from the current index/snapshot and are
      // registered together, so they always change on the same edge.
      anode_d = ~(4'b0001 << idx_q);
      seg_d   = blank_q ? 7'h7F : hex7(snap_q[{idx_q, 2'b00} +: 4]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         lvl_q        <= '0;
         cnt_q[0]     <= '0;
         cnt_q[1]     <= '0;
         step_pulse_q <= 1'b0;
         page_q       <= 1'b0;
         ref_q        <= '0;
         idx_q        <= '0;
         pend_q       <= 1'b1;
         snap_q       <= '0;
         blank_q      <= 1'b0;
         anode_q      <= 4'b1110;
         seg_q        <= 7'h40;
      end else begin
         sync1_q      <= {bus.btn_page, bus.btn_step};
         sync2_q      <= sync1_q;
         lvl_q        <= lvl_d;
         cnt_q[0]     <= cnt_d[0];
         cnt_q[1]     <= cnt_d[1];
         step_pulse_q <= step_pulse_d;
         page_q       <= page_d;
         ref_q        <= ref_d;
         idx_q        <= idx_d;
         pend_q       <= 1'b0;
         snap_q       <= snap_d;
         blank_q      <= blank_d;
         anode_q      <= anode_d;
         seg_q        <= seg_d;
      end
   end

   assign bus.step_pulse = step_pulse_q;
   assign bus.page       = page_q;
   assign bus.anode      = anode_q;
   assign bus.seg        = seg_q;

endmodule
